// File: rtl/chip8_pkg.sv
// Shared geometry, pixel types and scanout FSM states for the CHIP-8 display path.
package chip8_pkg;

    localparam int FB_W      = 64;
    localparam int FB_H      = 32;
    localparam int FB_DEPTH  = 2048;
    localparam int FB_ADDR_W = $clog2(FB_DEPTH);

    typedef logic [31:0] pixel_t;

    localparam pixel_t PIX_ON  = 32'hFFFF_FFFF;
    localparam pixel_t PIX_OFF = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN,
        DONE
    } scanout_state_t;

    // One converted source pixel plus the markers it carries into the output raster.
    typedef struct packed {
        pixel_t data;
        logic   sof;
        logic   eol;
        logic   eof;
    } pix_entry_t;

endpackage

// File: rtl/chip8_skid_buf.sv
// Two-entry buffer between framebuffer read return and the pixel stream.
module chip8_skid_buf
    import chip8_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  pix_entry_t in_data,
    output logic       out_valid,
    input  logic       out_ready,
    output pix_entry_t out_data,
    output logic [1:0] count
);

    pix_entry_t mem [2];
    logic       wr_ptr;
    logic       rd_ptr;
    logic       push;
    logic       pop;

    // The upstream credit check keeps pushes away from a full buffer.
    assign push      = in_valid && (count != 2'd2);
    assign pop       = out_valid && out_ready;
    assign out_valid = (count != 2'd0);
    assign out_data  = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= in_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + 2'(push) - 2'(pop);
        end
    end

endmodule

// File: rtl/chip8_scanout.sv
// Reads the 64x32 CHIP-8 framebuffer on request and streams a SCALE-replicated raster.
module chip8_scanout #(
    parameter int          FB_W      = chip8_pkg::FB_W,
    parameter int          FB_H      = chip8_pkg::FB_H,
    parameter int          SCALE     = 10,
    parameter logic [31:0] ON_COLOR  = chip8_pkg::PIX_ON,
    parameter logic [31:0] OFF_COLOR = chip8_pkg::PIX_OFF
) (
    input  logic                            clk_in,
    input  logic                            rst_n_in,
    input  logic                            frame_req_in,
    output logic                            busy_out,
    output logic                            fb_rd_en_out,
    output logic [chip8_pkg::FB_ADDR_W-1:0] fb_rd_addr_out,
    input  logic [31:0]                     fb_rd_data_in,
    output logic                            pix_valid_out,
    input  logic                            pix_ready_in,
    output logic [31:0]                     pix_data_out,
    output logic                            pix_sof_out,
    output logic                            pix_eol_out,
    output logic                            pix_eof_out,
    output logic                            frame_done_out
);
    import chip8_pkg::*;

    localparam int         SX_W    = $clog2(FB_W);
    localparam int         SY_W    = $clog2(FB_H);
    localparam logic [3:0] SC_LAST = 4'(SCALE - 1);

    scanout_state_t  state;
    logic [SX_W-1:0] sx;
    logic [SY_W-1:0] sy;
    logic [3:0]      ry;
    logic [3:0]      rx;
    logic [2:0]      rd_mark;
    logic [2:0]      ret_mark;
    logic            ret_vld;
    pix_entry_t      push_entry;
    pix_entry_t      head;
    logic            head_vld;
    logic [1:0]      occ;
    logic            xfer;
    logic            pop;
    logic            can_issue;
    logic            issue;
    logic            src_sof;
    logic            src_eol;
    logic            last_read;

    // Stream handshake: a pixel moves when pix_valid_out && pix_ready_in; while stalled the
    // head entry and rx are frozen, so data and markers hold and valid cannot drop.
    always_comb begin
        xfer      = head_vld && pix_ready_in;
        pop       = xfer && (rx == SC_LAST);
        // Occupancy and in-flight reads as they will stand next cycle, before this issue.
        can_issue = ({1'b0, occ} + 3'(ret_vld) + 3'(fb_rd_en_out) - 3'(pop)) < 3'd2;
        issue     = (state == FETCH) ? can_issue
                                     : ((state == IDLE || state == DONE) && frame_req_in);
        src_sof   = (sx == '0) && (sy == '0) && (ry == '0);
        src_eol   = (sx == SX_W'(FB_W - 1));
        last_read = src_eol && (sy == SY_W'(FB_H - 1)) && (ry == SC_LAST);
        push_entry.data = (fb_rd_data_in != '0) ? ON_COLOR : OFF_COLOR;
        {push_entry.sof, push_entry.eol, push_entry.eof} = ret_mark;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state          <= IDLE;
            busy_out       <= 1'b0;
            frame_done_out <= 1'b0;
            fb_rd_en_out   <= 1'b0;
            fb_rd_addr_out <= '0;
            sx             <= '0;
            sy             <= '0;
            ry             <= '0;
            rx             <= '0;
            rd_mark        <= '0;
            ret_mark       <= '0;
            ret_vld        <= 1'b0;
        end else begin
            fb_rd_en_out   <= issue;
            frame_done_out <= 1'b0;
            ret_vld        <= fb_rd_en_out;
            ret_mark       <= rd_mark;
            if (issue) begin
                fb_rd_addr_out <= FB_ADDR_W'(sy) * FB_ADDR_W'(FB_W) + FB_ADDR_W'(sx);
                rd_mark        <= {src_sof, src_eol, last_read};
                if (src_eol) begin
                    sx <= '0;
                    if (ry == SC_LAST) begin
                        ry <= '0;
                        sy <= (sy == SY_W'(FB_H - 1)) ? '0 : sy + 1'b1;
                    end else begin
                        ry <= ry + 4'd1;
                    end
                end else begin
                    sx <= sx + 1'b1;
                end
            end
            if (xfer) begin
                rx <= (rx == SC_LAST) ? 4'd0 : rx + 4'd1;
            end
            case (state)
                IDLE, DONE: begin
                    if (frame_req_in) begin
                        state    <= FETCH;
                        busy_out <= 1'b1;
                    end else begin
                        state    <= IDLE;
                        busy_out <= 1'b0;
                    end
                end
                FETCH: begin
                    if (issue && last_read) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (xfer && pix_eof_out) begin
                        state          <= DONE;
                        busy_out       <= 1'b0;
                        frame_done_out <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    chip8_skid_buf u_buf (
        .clk       (clk_in),
        .rst_n     (rst_n_in),
        .in_valid  (ret_vld),
        .in_data   (push_entry),
        .out_valid (head_vld),
        .out_ready (pop),
        .out_data  (head),
        .count     (occ)
    );

    assign pix_valid_out = head_vld;
    assign pix_data_out  = head_vld ? head.data : '0;
    assign pix_sof_out   = head_vld && head.sof && (rx == 4'd0);
    assign pix_eol_out   = head_vld && head.eol && (rx == SC_LAST);
    assign pix_eof_out   = head_vld && head.eof && (rx == SC_LAST);

endmodule

// File: tb/tb_chip8_scanout.sv
// Directed bench for chip8_scanout at SCALE=2 with a framebuffer model and pixel scoreboard.
module tb_chip8_scanout;

    localparam int SCALE = 2;
    localparam int OUT_W = 64 * SCALE;
    localparam int NPIX  = OUT_W * 32 * SCALE;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic        frame_req_in;
    logic        busy_out;
    logic        fb_rd_en_out;
    logic [10:0] fb_rd_addr_out;
    logic [31:0] fb_rd_data_in = '0;
    logic        pix_valid_out;
    logic        pix_ready_in;
    logic [31:0] pix_data_out;
    logic        pix_sof_out;
    logic        pix_eol_out;
    logic        pix_eof_out;
    logic        frame_done_out;

    logic [31:0] fb [2048];
    logic [34:0] exp_q[$];
    int          cyc = 0;
    int          check_cnt = 0;
    int          pass_cnt = 0;
    int          xfers = 0;
    int          reads = 0;
    int          done_cnt = 0;
    int          last_eof_cyc = 0;
    logic        bp_mode = 1'b0;
    logic        prev_done = 1'b0;
    logic        prev_req = 1'b0;
    logic        prev_stall = 1'b0;
    logic [35:0] prev_word = '0;

    chip8_scanout #(.SCALE(SCALE)) u_dut (
        .clk_in         (clk_in),
        .rst_n_in       (rst_n_in),
        .frame_req_in   (frame_req_in),
        .busy_out       (busy_out),
        .fb_rd_en_out   (fb_rd_en_out),
        .fb_rd_addr_out (fb_rd_addr_out),
        .fb_rd_data_in  (fb_rd_data_in),
        .pix_valid_out  (pix_valid_out),
        .pix_ready_in   (pix_ready_in),
        .pix_data_out   (pix_data_out),
        .pix_sof_out    (pix_sof_out),
        .pix_eol_out    (pix_eol_out),
        .pix_eof_out    (pix_eof_out),
        .frame_done_out (frame_done_out)
    );

    // Clock, cycle counter and 1-cycle-latency framebuffer read port.
    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) begin
        cyc <= cyc + 1;
        if (fb_rd_en_out) fb_rd_data_in <= fb[fb_rd_addr_out];
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        check_cnt++;
        if (got !== exp) $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
        else pass_cnt++;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic pulse_req();
        frame_req_in = 1'b1;
        tick(1);
        frame_req_in = 1'b0;
    endtask

    task automatic load_expected();
        for (int k = 0; k < NPIX; k++) begin
            int x;
            int y;
            logic [31:0] w;
            x = k % OUT_W;
            y = k / OUT_W;
            w = (fb[(y / SCALE) * 64 + x / SCALE] != 0) ? 32'hFFFF_FFFF : 32'h0;
            exp_q.push_back({w, (k == 0), (x == OUT_W - 1), (k == NPIX - 1)});
        end
    endtask

    task automatic wait_done(input int target, input int budget);
        int i;
        i = 0;
        while (done_cnt < target && i < budget) begin
            @(posedge clk_in);
            i++;
        end
        #1;
        check("frame_done_seen", (done_cnt >= target), 1);
    endtask

    // Request in cycle N: read strobe at N+1, first pixel at N+3 carrying sof.
    task automatic start_checked();
        frame_req_in = 1'b1;
        tick(1);
        frame_req_in = 1'b0;
        check("lat_rd_en", fb_rd_en_out, 1);
        check("lat_addr0", fb_rd_addr_out, 0);
        check("lat_busy", busy_out, 1);
        tick(1);
        check("lat_valid_early", pix_valid_out, 0);
        tick(1);
        check("lat_valid", pix_valid_out, 1);
        check("lat_sof", pix_sof_out, 1);
    endtask

    initial begin
        pix_ready_in = 1'b1;
        forever begin
            @(posedge clk_in);
            #1;
            pix_ready_in = bp_mode ? ($urandom_range(0, 99) >= 30) : 1'b1;
        end
    end

    // Scoreboard and protocol monitor, sampled on the falling edge.
    always @(negedge clk_in) begin
        if (!rst_n_in) begin
            xfers      = 0;
            reads      = 0;
            prev_stall = 1'b0;
            prev_done  = 1'b0;
            prev_req   = 1'b0;
        end else begin
            if (prev_stall)
                check("stall_hold", {pix_valid_out, pix_data_out, pix_sof_out, pix_eol_out,
                                     pix_eof_out}, prev_word);
            if (fb_rd_en_out) reads++;
            if (busy_out) check("occupancy_le2", ((reads - xfers / SCALE) <= 2), 1);
            if (pix_valid_out && pix_ready_in) begin
                if (exp_q.size() == 0) check("extra_pixel", 1, 0);
                else check("pixel", {pix_data_out, pix_sof_out, pix_eol_out, pix_eof_out},
                           exp_q.pop_front());
                if (pix_eof_out) last_eof_cyc = cyc;
                xfers++;
            end
            if (frame_done_out) begin
                check("done_after_eof", cyc - last_eof_cyc, 1);
                check("done_not_busy", busy_out, 0);
                done_cnt++;
            end
            if (prev_done) begin
                check("done_width", frame_done_out, 0);
                check("restart_busy", busy_out, prev_req);
                check("restart_rd_en", fb_rd_en_out, prev_req);
            end
            prev_done  = frame_done_out;
            prev_req   = frame_req_in;
            prev_stall = pix_valid_out && !pix_ready_in;
            prev_word  = {pix_valid_out, pix_data_out, pix_sof_out, pix_eol_out, pix_eof_out};
        end
    end

    initial begin
        int d;
        for (int i = 0; i < 2048; i++) fb[i] = '0;
        rst_n_in     = 1'b0;
        frame_req_in = 1'b0;
        #1;
        check("reset_outputs", {busy_out, fb_rd_en_out, fb_rd_addr_out, pix_valid_out,
                                pix_data_out, pix_sof_out, pix_eol_out, pix_eof_out,
                                frame_done_out}, 0);
        tick(3);
        rst_n_in = 1'b1;
        tick(2);
        check("idle_busy", busy_out, 0);
        check("idle_valid", pix_valid_out, 0);

        // Frame 1: dark framebuffer, latency and markers.
        load_expected();
        start_checked();
        wait_done(1, 20000);
        check("frame1_all_pixels", exp_q.size(), 0);
        tick(5);
        check("idle_after_frame1", busy_out, 0);

        // Frame 2: two lit source pixels, request pulsed mid-frame must be ignored.
        fb[0]  = 32'hFFFF_FFFF;
        fb[65] = 32'h0000_0001;
        load_expected();
        pulse_req();
        tick(3000);
        pulse_req();
        wait_done(2, 20000);
        check("frame2_all_pixels", exp_q.size(), 0);
        tick(20);
        check("midframe_req_ignored", busy_out, 0);
        check("frame2_single_done", done_cnt, 2);

        // Frame 3: same picture under random backpressure.
        bp_mode = 1'b1;
        load_expected();
        pulse_req();
        wait_done(3, 40000);
        check("frame3_all_pixels", exp_q.size(), 0);
        bp_mode = 1'b0;
        tick(5);

        // Frames 4 and 5: request held high, back to back through one DONE cycle.
        load_expected();
        load_expected();
        frame_req_in = 1'b1;
        wait_done(4, 20000);
        frame_req_in = 1'b0;
        wait_done(5, 20000);
        check("frames45_all_pixels", exp_q.size(), 0);
        tick(5);

        // Frame 6: reset at pixel 1000 abandons the frame.
        load_expected();
        pulse_req();
        for (int i = 0; i < 5000 && exp_q.size() > NPIX - 1000; i++) tick(1);
        check("reset_point_reached", (exp_q.size() <= NPIX - 1000), 1);
        d = done_cnt;
        #2;
        rst_n_in = 1'b0;
        #1;
        check("async_reset_outputs", {busy_out, fb_rd_en_out, fb_rd_addr_out, pix_valid_out,
                                      pix_data_out, pix_sof_out, pix_eol_out, pix_eof_out,
                                      frame_done_out}, 0);
        exp_q.delete();
        tick(3);
        rst_n_in = 1'b1;
        tick(5);
        check("no_done_after_reset", done_cnt, d);
        check("idle_after_reset", busy_out, 0);

        // Frame 7: clean restart from address 0 with sof.
        load_expected();
        start_checked();
        wait_done(d + 1, 20000);
        check("frame7_all_pixels", exp_q.size(), 0);
        tick(3);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
